key_converter: RTL and testbench
================================

# key_converter

Keyboard decoder for the game controller. Translates the raw 8-bit ASCII key byte from the keyboard/UART receiver into the 4-bit key enumeration consumed by the game state machine (`Machine`). Sits between the keyboard receiver and the state machine, one instance per system.

## Interface
Parameters:
- none (key codes are fixed constants, listed under Operation)

Ports:
- `clk`  input  1  system clock; all state updates on its rising edge
- `rst`  input  1  reset, asynchronous, active-high; forces all registers to reset values immediately
- `keyboard`  input  8  raw ASCII byte of the current key; 0x00 means no key
- `key`  output  4  decoded key code, registered

Port order in the instantiation is positional: `key`, `keyboard`, `clk`, `rst`.

## Operation
- Decode table. Upper and lower case are equivalent.
  - 'W'/'w' (0x57/0x77) -> 4'd1
  - 'A'/'a' (0x41/0x61) -> 4'd2
  - 'S'/'s' (0x53/0x73) -> 4'd3
  - 'D'/'d' (0x44/0x64) -> 4'd4
  - 'J'/'j' (0x4A/0x6A) -> 4'd5
  - 'K'/'k' (0x4B/0x6B) -> 4'd6
  - 'L'/'l' (0x4C/0x6C) -> 4'd7
  - space (0x20) -> 4'd8
- Any other byte, including 0x00 and bytes with bit 7 set, decodes to 4'd0 (none).
- Codes 9–15 are never produced.
- Level mode (default):
  - `key` follows the decoded `keyboard` value on every clock.
  - A held byte yields a constant code.
- Internal state:
  - `key` output register.
  - `prev` register, 8 bits: the last sampled byte, used by one-shot mode.
- No X propagation: an X or Z in `keyboard` decodes to 0.

## Timing
- Latency is 1 cycle. `keyboard` is sampled at rising edge n, and `key` shows the decoded code after edge n, stable until edge n+1.
- Reset values:
  - `key` = 0
  - `prev` = 0x00
- Reset asserted mid-operation clears `key` to 0 asynchronously, without waiting for a clock edge.
- First edge after reset deassertion:
  - `keyboard` is sampled normally.
  - In one-shot mode the comparison is against 0x00, so a byte already present at reset release produces a pulse.
- `keyboard` changing between edges has no effect until the next edge. No glitches appear on `key`.

## Configuration
- Macro `KEYCONV_ONESHOT_EN`.
- Undefined: level mode as above.
- Defined: one-shot mode.
  - `key` carries the decoded code for exactly one cycle, on the edge where the sampled `keyboard` differs from `prev` and decodes to a nonzero code. It is 0 on all other cycles.
  - `prev` updates every cycle.
  - Case change of the same letter (0x77 then 0x57) counts as a change and produces a second pulse.
  - Re-pressing the same key requires an intervening different byte (e.g. 0x00).

## Test plan
- Reset: assert `rst` with `keyboard`=0x77 -> `key`=0 immediately. Deassert; after the next edge -> `key`=1.
- Full decode sweep: drive each of W,w,A,a,S,s,D,d,J,j,K,k,L,l and 0x20 for one cycle each -> `key` = 1,1,2,2,3,3,4,4,5,5,6,6,7,7,8, each one edge later.
- Invalid bytes: drive 0x00, 0x41+0x80, 0x31, 0x58 ('X'), 0xFF -> `key`=0 for all.
- Hold, level mode: `keyboard`=0x64 for 10 cycles -> `key`=4 for 10 cycles. Then 0x00 -> `key`=0 after one edge.
- Hold, `KEYCONV_ONESHOT_EN` defined: `keyboard`=0x64 for 10 cycles -> `key`=4 for exactly one cycle, then 0.
  - 0x00 then 0x64 -> a second single pulse of 4.
  - 0x64 then 0x44 -> a pulse of 4 on the change.
- Async reset mid-hold: with `key`=8, pulse `rst` between clock edges -> `key`=0 without a clock edge. In one-shot mode, `prev` clears, so a held 0x20 pulses 8 again after release.

Source files
------------

// File: rtl/key_converter.sv
// ASCII key byte to 4-bit game key decoder with a registered output.
// Define KEYCONV_ONESHOT_EN to emit one-cycle pulses on key changes instead of levels.
module key_converter (
   output logic [3:0] key,
   input  logic [7:0] keyboard,
   input  logic       clk,
   input  logic       rst
);

   logic [3:0] w_code;
   logic [3:0] r_key;

   // X/Z bytes match no item and fall through to the default of 0.
   always_comb begin
      w_code = 4'd0;
      case (keyboard)
         8'h57, 8'h77: w_code = 4'd1;
         8'h41, 8'h61: w_code = 4'd2;
         8'h53, 8'h73: w_code = 4'd3;
         8'h44, 8'h64: w_code = 4'd4;
         8'h4A, 8'h6A: w_code = 4'd5;
         8'h4B, 8'h6B: w_code = 4'd6;
         8'h4C, 8'h6C: w_code = 4'd7;
         8'h20:        w_code = 4'd8;
         default:      w_code = 4'd0;
      endcase
   end

`ifdef KEYCONV_ONESHOT_EN
   logic [7:0] r_prev;
   logic       w_fire;

   // A case change of the same letter is a different byte and so fires again.
   assign w_fire = (keyboard != r_prev) && (w_code != 4'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_key  <= 4'd0;
         r_prev <= 8'h00;
      end else begin
         r_key  <= w_fire ? w_code : 4'd0;
         r_prev <= keyboard;
      end
   end
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_key <= 4'd0;
      end else begin
         r_key <= w_code;
      end
   end
`endif

   assign key = r_key;

endmodule

// File: tb/tb_key_converter.sv
// Directed-vector bench for key_converter; follows KEYCONV_ONESHOT_EN to pick hold expectations.
module tb_key_converter;

   logic       clk;
   logic       rst;
   logic [7:0] keyboard;
   logic [3:0] key;

   int n_vec;
   int n_bad;

   key_converter dut (
      .key      (key),
      .keyboard (keyboard),
      .clk      (clk),
      .rst      (rst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: key=%0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] sweep_in  [15] = '{8'h57, 8'h77, 8'h41, 8'h61, 8'h53, 8'h73, 8'h44, 8'h64,
                                  8'h4A, 8'h6A, 8'h4B, 8'h6B, 8'h4C, 8'h6C, 8'h20};
   logic [3:0] sweep_exp [15] = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd4, 4'd4,
                                  4'd5, 4'd5, 4'd6, 4'd6, 4'd7, 4'd7, 4'd8};
   logic [7:0] bad_in    [5]  = '{8'h00, 8'hC1, 8'h31, 8'h58, 8'hFF};

   initial begin
      n_vec    = 0;
      n_bad    = 0;
      rst      = 1'b1;
      keyboard = 8'h77;
      #2;
      chk("reset_async", key, 4'd0);
      tick();
      tick();
      chk("reset_held", key, 4'd0);
      #2 rst = 1'b0;
      tick();
      chk("reset_release", key, 4'd1);

      for (int i = 0; i < 15; i++) begin
         keyboard = sweep_in[i];
         tick();
         chk($sformatf("sweep_%02h", sweep_in[i]), key, sweep_exp[i]);
      end

      for (int i = 0; i < 5; i++) begin
         keyboard = bad_in[i];
         tick();
         chk($sformatf("invalid_%02h", bad_in[i]), key, 4'd0);
      end

      keyboard = 8'h64;
      for (int i = 0; i < 10; i++) begin
         tick();
`ifdef KEYCONV_ONESHOT_EN
         chk($sformatf("hold_%0d", i), key, (i == 0) ? 4'd4 : 4'd0);
`else
         chk($sformatf("hold_%0d", i), key, 4'd4);
`endif
      end
      keyboard = 8'h00;
      tick();
      chk("release", key, 4'd0);
      keyboard = 8'h64;
      tick();
      chk("repress", key, 4'd4);
      keyboard = 8'h44;
      tick();
      chk("case_change", key, 4'd4);
      tick();
`ifdef KEYCONV_ONESHOT_EN
      chk("case_change_hold", key, 4'd0);
`else
      chk("case_change_hold", key, 4'd4);
`endif

      // Asynchronous reset between edges while space is held.
      keyboard = 8'h00;
      tick();
      keyboard = 8'h20;
      tick();
      chk("space_before_rst", key, 4'd8);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_cycle", key, 4'd0);
      #1 rst = 1'b0;
      #1;
      chk("rst_no_edge", key, 4'd0);
      tick();
      chk("space_after_rst", key, 4'd8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
